// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg: shared states, instruction field positions, PC width.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cpu_pkg;

  localparam int unsigned PC_W_DEF = 15;
  localparam int unsigned INSTR_W  = 16;

  localparam int unsigned C_BIT    = 15;
  localparam int unsigned A_BIT    = 12;
  localparam int unsigned CTRL_MSB = 11;
  localparam int unsigned CTRL_LSB = 6;
  localparam int unsigned DEST_A   = 5;
  localparam int unsigned DEST_D   = 4;
  localparam int unsigned DEST_M   = 3;
  localparam int unsigned J_LT     = 2;
  localparam int unsigned J_EQ     = 1;
  localparam int unsigned J_GT     = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    HALT  = 2'd3
  } state_t;

  function automatic logic is_c_instr(input logic [INSTR_W-1:0] w);
    return w[C_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_sequencer_jump_cond.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jump_cond: decides whether a C-instruction jump is taken.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module jump_cond
  import cpu_pkg::*;
(
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_taken
);

  assign o_taken = (i_j[J_LT] & i_ng) |
                   (i_j[J_EQ] & i_zr) |
                   (i_j[J_GT] & ~i_zr & ~i_ng);

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_ctrl_sequencer: FETCH/EXEC/WB control unit for a Hack ALU.     |
// | Optional halt-on-self-jump via macro HALT_DETECT_EN.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned        PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  input  logic [15:0]       mem_rdata,
  output logic [PC_W-1:0]   addr_m,
  output logic [15:0]       out_m,
  output logic              write_m,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic              zx,
  output logic              nx,
  output logic              zy,
  output logic              ny,
  output logic              f,
  output logic              no,
  input  logic [15:0]       alu_out,
  input  logic              zr,
  input  logic              ng
`ifdef HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_instr;
  logic [15:0]       r_a;
  logic [15:0]       r_d;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_res;
  logic              r_zr;
  logic              r_ng;
  logic [15:0]       r_x_hold;
  logic [15:0]       r_y_hold;
  logic              w_taken;
  logic              w_halt;
  logic              w_is_c;

  assign w_is_c = is_c_instr(r_instr);

  jump_cond u_jump_cond (
    .i_j     (r_instr[2:0]),
    .i_zr    (r_zr),
    .i_ng    (r_ng),
    .o_taken (w_taken)
  );

`ifdef HALT_DETECT_EN
  // Unconditional jump onto its own address can never make progress.
  assign w_halt = w_is_c && (r_instr[2:0] == 3'b111) && (r_a[PC_W-1:0] == r_pc);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: if (instr_valid) w_state_nxt = is_c_instr(instr) ? EXEC : WB;
      EXEC:  w_state_nxt = WB;
      WB:    w_state_nxt = w_halt ? HALT : FETCH;
      HALT:  w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == FETCH);
    write_m     = 1'b0;
    out_m       = '0;
    {zx, nx, zy, ny, f, no} = 6'b0;
    alu_x       = r_x_hold;
    alu_y       = r_y_hold;
    if (r_state == EXEC) begin
      {zx, nx, zy, ny, f, no} = r_instr[CTRL_MSB:CTRL_LSB];
      alu_x = r_d;
      alu_y = r_instr[A_BIT] ? mem_rdata : r_a;
    end
    if (r_state == WB && w_is_c && r_instr[DEST_M]) begin
      write_m = 1'b1;
      out_m   = r_res;
    end
  end

`ifdef HALT_DETECT_EN
  assign halted = (r_state == HALT);
`endif

  assign pc     = r_pc;
  assign addr_m = r_a[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_pc     <= RESET_PC;
      r_res    <= '0;
      r_zr     <= 1'b0;
      r_ng     <= 1'b0;
      r_x_hold <= '0;
      r_y_hold <= '0;
    end else begin
      case (r_state)
        FETCH: if (instr_valid) r_instr <= instr;
        EXEC: begin
          r_res    <= alu_out;
          r_zr     <= zr;
          r_ng     <= ng;
          r_x_hold <= alu_x;
          r_y_hold <= alu_y;
        end
        WB: begin
          if (!w_is_c) begin
            r_a  <= {1'b0, r_instr[14:0]};
            r_pc <= r_pc + PC_W'(1);
          end else begin
            if (r_instr[DEST_A]) r_a <= r_res;
            if (r_instr[DEST_D]) r_d <= r_res;
            // Jump target is the A value from before this writeback.
            if (!w_halt) r_pc <= w_taken ? r_a[PC_W-1:0] : r_pc + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_ctrl_sequencer: directed bench with a Hack ALU model.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alu_ctrl_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] mem_rdata;
  logic [14:0] addr_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        zx, nx, zy, ny, f, no, zr, ng;
`ifdef HALT_DETECT_EN
  logic        halted;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int wm_cnt  = 0;

  always #5 clk = ~clk;

  alu_ctrl_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .mem_rdata(mem_rdata), .addr_m(addr_m),
    .out_m(out_m), .write_m(write_m), .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .zr(zr), .ng(ng)
`ifdef HALT_DETECT_EN
    , .halted(halted)
`endif
  );

  assign mem_rdata = 16'hBEEF;

  logic [15:0] xv, yv, rv;
  always_comb begin
    xv = zx ? 16'h0 : alu_x;
    if (nx) xv = ~xv;
    yv = zy ? 16'h0 : alu_y;
    if (ny) yv = ~yv;
    rv = f ? (xv + yv) : (xv & yv);
    if (no) rv = ~rv;
    alu_out = rv;
    zr = (rv == 16'h0);
    ng = rv[15];
  end

  always @(posedge clk) begin
    #1;
    if (write_m) wm_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents a word and returns at the first negedge after it was accepted.
  task automatic fetch(input logic [15:0] w);
    int n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("fetch_timeout", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic run_a(input logic [15:0] w);
    fetch(w);
    @(negedge clk);
  endtask

  task automatic run_c(input logic [15:0] w);
    fetch(w);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_state", 32'(dut.r_state), 32'(FETCH));
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_a", 32'(addr_m), 32'd0);
    chk("rst_d", 32'(dut.r_d), 32'd0);
    chk("rst_outs", {write_m, out_m, zx, nx, zy, ny, f, no}, 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);

    // @5: two cycles, no memory write
    wm_cnt = 0;
    fetch(16'h0005);
    chk("ainstr_wb_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("ainstr_a", 32'(addr_m), 32'd5);
    chk("ainstr_pc", 32'(pc), 32'd1);
    chk("ainstr_state", 32'(dut.r_state), 32'(FETCH));
    chk("ainstr_nowm", 32'(wm_cnt), 32'd0);

    // D=A
    fetch(16'hEC10);
    chk("da_ctrl", 32'({zx, nx, zy, ny, f, no}), 32'b110000);
    chk("da_alu_y", 32'(alu_y), 32'd5);
    chk("da_exec_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("da_wb_ctrl", 32'({zx, nx, zy, ny, f, no}), 32'd0);
    @(negedge clk);
    chk("da_d", 32'(dut.r_d), 32'd5);
    chk("da_pc", 32'(pc), 32'd2);

    // M=D+1 with A=100, D=7
    run_a(16'h0007);
    run_c(16'hEC10);
    run_a(16'h0064);
    wm_cnt = 0;
    fetch(16'hE7C8);
    chk("md1_exec_wm", 32'(write_m), 32'd0);
    @(negedge clk);
    chk("md1_wm", 32'(write_m), 32'd1);
    chk("md1_addr", 32'(addr_m), 32'd100);
    chk("md1_out", 32'(out_m), 32'd8);
    @(negedge clk);
    chk("md1_wm_after", 32'(write_m), 32'd0);
    chk("md1_wm_cnt", 32'(wm_cnt), 32'd1);
    chk("md1_a", 32'(addr_m), 32'd100);
    chk("md1_d", 32'(dut.r_d), 32'd7);
    chk("md1_pc", 32'(pc), 32'd6);

    // AM=0;JEQ with A=20
    run_a(16'h0014);
    fetch(16'hEAAA);
    @(negedge clk);
    chk("jeq_wm", 32'(write_m), 32'd1);
    chk("jeq_addr", 32'(addr_m), 32'd20);
    chk("jeq_out", 32'(out_m), 32'd0);
    @(negedge clk);
    chk("jeq_pc", 32'(pc), 32'd20);
    chk("jeq_a", 32'(addr_m), 32'd0);

    // Stall with no valid instruction
    repeat (4) @(negedge clk);
    chk("stall_state", 32'(dut.r_state), 32'(FETCH));
    chk("stall_pc", 32'(pc), 32'd20);
    chk("stall_ready", 32'(instr_ready), 32'd1);

    // Reset during EXEC of M=D+1 (D=7)
    wm_cnt = 0;
    fetch(16'hE7C8);
    chk("mid_exec_state", 32'(dut.r_state), 32'(EXEC));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(dut.r_state), 32'(FETCH));
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_d", 32'(dut.r_d), 32'd0);
    @(negedge clk);
    chk("mid_rst_nowm", 32'(wm_cnt), 32'd0);

    // PC wrap: jump to 0x7FFF, then a non-jump instruction
    run_a(16'h7FFF);
    run_c(16'hEA87);
    chk("wrap_pc_top", 32'(pc), 32'h7FFF);
    run_a(16'h0003);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_a", 32'(addr_m), 32'd3);

`ifdef HALT_DETECT_EN
    run_c(16'hEA87);
    chk("halt_pc3", 32'(pc), 32'd3);
    run_a(16'h0003);
    run_c(16'hEA87);
    chk("halt_first_pass", 32'(pc), 32'd3);
    chk("halt_not_yet", 32'(halted), 32'd0);
    run_a(16'h0004);
    fetch(16'hEA87);
    @(negedge clk);
    @(negedge clk);
    chk("halted", 32'(halted), 32'd1);
    instr_valid = 1'b1;
    begin
      int rdy_seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (instr_ready) rdy_seen++;
        @(negedge clk);
      end
      chk("halt_ready", 32'(rdy_seen), 32'd0);
    end
    chk("halt_pc", 32'(pc), 32'd4);
    instr_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
